// File: rtl/adau1761_cfg_pkg.sv
// rtl/adau1761_cfg_pkg.sv - shared types and cycle-count helpers for the ADAU1761 config sequencer
package adau1761_cfg_pkg;

  typedef enum logic [1:0] {
    KIND_WRITE = 2'b00,
    KIND_DELAY = 2'b01,
    KIND_RSVD  = 2'b10,
    KIND_END   = 2'b11
  } kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_XFER,
    ST_GAP,
    ST_DELAY,
    ST_FIN,
    ST_FAIL
  } state_e;

  // Write entries use reg_addr/data; delay entries reuse the low 16 bits as a ms count.
  typedef struct packed {
    kind_e       kind;
    logic [5:0]  rsvd;
    logic [15:0] reg_addr;
    logic [7:0]  data;
  } entry_t;

  localparam logic [31:0] ENTRY_END = 32'hC000_0000;

  function automatic logic [31:0] gap_cyc(input int unsigned freq_mhz, input int unsigned us);
    return 32'(freq_mhz * us);
  endfunction

  function automatic logic [31:0] ms_cyc(input int unsigned freq_mhz);
    return 32'(freq_mhz * 1000);
  endfunction

  function automatic logic [31:0] timeout_cyc(input int unsigned freq_mhz, input int unsigned ms);
    return 32'(freq_mhz * ms * 1000);
  endfunction

  function automatic logic [15:0] delay_ms(input entry_t e);
    return {e.reg_addr[7:0], e.data};
  endfunction

  function automatic logic [31:0] mk_wr(input logic [15:0] addr, input logic [7:0] data);
    return {KIND_WRITE, 6'd0, addr, data};
  endfunction

  function automatic logic [31:0] mk_dly(input logic [15:0] ms);
    return {KIND_DELAY, 14'd0, ms};
  endfunction

endpackage

// File: rtl/adau1761_cfg_rom.sv
// rtl/adau1761_cfg_rom.sv - constant codec init table, optionally replaced by a parameter table
module adau1761_cfg_rom
  import adau1761_cfg_pkg::*;
#(
  parameter bit           OVR_EN   = 1'b0,
  parameter logic [511:0] OVR_TBL  = '0,
  parameter logic [31:0]  OVR_FILL = ENTRY_END
) (
  input  logic [7:0] idx,
  output entry_t     entry
);

  logic [31:0] word;

  // Table lookup: the override table covers idx 0..15, everything beyond reads OVR_FILL.
  always_comb begin
    word = ENTRY_END;
    if (OVR_EN) begin
      if (idx < 8'd16) begin
        word = OVR_TBL[{idx[3:0], 5'd0} +: 32];
      end else begin
        word = OVR_FILL;
      end
    end else begin
      case (idx)
        8'd0:    word = mk_wr(16'h4000, 8'h0E);  // clock control: PLL source, core off
        8'd1:    word = mk_wr(16'h4007, 8'h01);  // PLL enable
        8'd2:    word = mk_dly(16'd10);          // PLL lock time
        8'd3:    word = mk_wr(16'h4000, 8'h0F);  // core clock on
        8'd4:    word = mk_wr(16'h4015, 8'h01);  // serial port 0: master
        8'd5:    word = mk_wr(16'h4016, 8'h00);  // serial port 1
        8'd6:    word = mk_wr(16'h401C, 8'h21);  // mixer 3: left DAC
        8'd7:    word = mk_wr(16'h401E, 8'h41);  // mixer 4: right DAC
        8'd8:    word = mk_wr(16'h4029, 8'h03);  // playback power
        8'd9:    word = mk_wr(16'h402A, 8'h03);  // DAC control
        8'd10:   word = mk_wr(16'h40F9, 8'h7F);  // clock enable 0
        8'd11:   word = mk_wr(16'h40FA, 8'h03);  // clock enable 1
        default: word = ENTRY_END;
      endcase
    end
  end

  assign entry = entry_t'(word);

endmodule

// File: rtl/adau1761_cfg_seq.sv
// rtl/adau1761_cfg_seq.sv - boot-time register write sequencer driving a byte-level I2C controller
module adau1761_cfg_seq
  import adau1761_cfg_pkg::*;
#(
  parameter int unsigned  CLOCKFREQ       = 50,
  parameter logic [7:0]   DEV_ADDR        = 8'h76,
  parameter int unsigned  MAX_RETRY       = 3,
  parameter int unsigned  GAP_US          = 5,
  parameter int unsigned  XFER_TIMEOUT_MS = 2,
  parameter bit           ROM_OVR_EN      = 1'b0,
  parameter logic [511:0] ROM_OVR_TBL     = '0,
  parameter logic [31:0]  ROM_OVR_FILL    = ENTRY_END
) (
  input  logic       CLK,
  input  logic       SRST,
  input  logic       START_I,
  output logic       BUSY_O,
  output logic       DONE_O,
  output logic       ERR_O,
  output logic [7:0] ERR_IDX_O,
  output logic       TWI_STB_O,
  output logic [7:0] TWI_A_O,
  output logic [7:0] TWI_D_O,
  input  logic       TWI_DONE_I,
  input  logic       TWI_ERR_I
);

  localparam logic [31:0] GAP_CYC   = gap_cyc(CLOCKFREQ, GAP_US);
  localparam logic [31:0] MS_CYC    = ms_cyc(CLOCKFREQ);
  localparam logic [31:0] TO_CYC    = timeout_cyc(CLOCKFREQ, XFER_TIMEOUT_MS);
  // Down-counters stop at zero, so load N-1 to spend exactly N cycles.
  localparam logic [31:0] GAP_LOAD  = (GAP_CYC == 32'd0) ? 32'd0 : GAP_CYC - 32'd1;
  localparam logic [31:0] TO_LOAD   = (TO_CYC == 32'd0) ? 32'd0 : TO_CYC - 32'd1;
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  entry_t      rom_entry;
  logic        rom_unused;
  logic [31:0] dly_cyc;

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  retry_q, retry_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wdog_q, wdog_d;
  logic        stb_q, stb_d;
  logic [7:0]  tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  err_idx_q, err_idx_d;
  logic        xfer_fail;

  adau1761_cfg_rom #(
    .OVR_EN   (ROM_OVR_EN),
    .OVR_TBL  (ROM_OVR_TBL),
    .OVR_FILL (ROM_OVR_FILL)
  ) u_rom (
    .idx   (idx_q),
    .entry (rom_entry)
  );

  assign rom_unused = ^rom_entry.rsvd;
  assign dly_cyc    = 32'(delay_ms(rom_entry)) * MS_CYC;

  // Next-state logic: table walk, byte handshake, retries, gap/delay timing and watchdog.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    wdog_d     = wdog_q;
    stb_d      = stb_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    xfer_fail  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stb_d = 1'b0;
        if (START_I) begin
          idx_d     = 8'd0;
          retry_d   = 8'd0;
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = 8'd0;
          busy_d    = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_FETCH: begin
        addr_d     = rom_entry.reg_addr;
        data_d     = rom_entry.data;
        byte_cnt_d = 2'd0;
        case (rom_entry.kind)
          KIND_WRITE: begin
            stb_d   = 1'b1;
            tx_d    = rom_entry.reg_addr[15:8];
            wdog_d  = TO_LOAD;
            state_d = ST_XFER;
          end
          KIND_DELAY: begin
            cnt_d   = (dly_cyc == 32'd0) ? 32'd0 : dly_cyc - 32'd1;
            state_d = ST_DELAY;
          end
          default: state_d = ST_FIN;
        endcase
      end

      ST_XFER: begin
        if (TWI_DONE_I) begin
          wdog_d = TO_LOAD;
          if (TWI_ERR_I) begin
            xfer_fail = 1'b1;
          end else if (byte_cnt_q != 2'd2) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            tx_d       = (byte_cnt_q == 2'd0) ? addr_q[7:0] : data_q;
          end else begin
            stb_d   = 1'b0;
            retry_d = 8'd0;
            if (idx_q == 8'hFF) begin
              state_d = ST_FAIL;
            end else begin
              idx_d   = idx_q + 8'd1;
              cnt_d   = GAP_LOAD;
              state_d = ST_GAP;
            end
          end
        end else if (wdog_q == 32'd0) begin
          xfer_fail = 1'b1;
        end else begin
          wdog_d = wdog_q - 32'd1;
        end

        if (xfer_fail) begin
          stb_d = 1'b0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 8'd1;
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end

      ST_GAP: begin
        if (cnt_q == 32'd0) begin
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      ST_DELAY: begin
        if (cnt_q == 32'd0) begin
          if (idx_q == 8'hFF) begin
            state_d = ST_FAIL;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_FETCH;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      ST_FAIL: begin
        err_d     = 1'b1;
        err_idx_d = idx_q;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        stb_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; SRST drops the strobe and returns everything to IDLE.
  always_ff @(posedge CLK) begin
    if (SRST) begin
      state_q    <= ST_IDLE;
      idx_q      <= 8'd0;
      retry_q    <= 8'd0;
      byte_cnt_q <= 2'd0;
      addr_q     <= 16'd0;
      data_q     <= 8'd0;
      cnt_q      <= 32'd0;
      wdog_q     <= 32'd0;
      stb_q      <= 1'b0;
      tx_q       <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      wdog_q     <= wdog_d;
      stb_q      <= stb_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign BUSY_O    = busy_q;
  assign DONE_O    = done_q;
  assign ERR_O     = err_q;
  assign ERR_IDX_O = err_idx_q;
  assign TWI_STB_O = stb_q;
  assign TWI_A_O   = DEV_ADDR;
  assign TWI_D_O   = tx_q;

endmodule

// File: tb/tb_adau1761_cfg_seq.sv
// tb/tb_adau1761_cfg_seq.sv - directed and randomized check of the config sequencer against a table-walk model
module tb_adau1761_cfg_seq;
  import adau1761_cfg_pkg::*;

  localparam int unsigned FREQ = 1;
  localparam int unsigned MAXR = 3;
  localparam int unsigned GAPU = 5;
  localparam int unsigned TOMS = 2;
  localparam int TOC  = TOMS * 1000 * FREQ;
  localparam int GAPC = GAPU * FREQ;
  localparam int MSC  = 1000 * FREQ;

  localparam logic [511:0] TEST_TBL = {{11{ENTRY_END}},
                                       mk_wr(16'h401C, 8'h21),
                                       mk_dly(16'd2),
                                       mk_wr(16'h4017, 8'h00),
                                       mk_wr(16'h4015, 8'h01),
                                       mk_wr(16'h4000, 8'h01)};
  localparam logic [511:0] WRAP_TBL = {16{mk_dly(16'd0)}};

  logic clk = 1'b0;
  logic srst, start, busy, done, err, stb, twi_done, twi_err;
  logic [7:0] err_idx, twi_a, twi_d;
  logic w_start, w_busy, w_done, w_err, w_stb, w_twi_done, w_twi_err;
  logic [7:0] w_err_idx, w_twi_a, w_twi_d;

  always #5 clk = ~clk;

  adau1761_cfg_seq #(
    .CLOCKFREQ(FREQ), .DEV_ADDR(8'h76), .MAX_RETRY(MAXR), .GAP_US(GAPU), .XFER_TIMEOUT_MS(TOMS),
    .ROM_OVR_EN(1'b1), .ROM_OVR_TBL(TEST_TBL), .ROM_OVR_FILL(ENTRY_END)
  ) dut (
    .CLK(clk), .SRST(srst), .START_I(start), .BUSY_O(busy), .DONE_O(done), .ERR_O(err),
    .ERR_IDX_O(err_idx), .TWI_STB_O(stb), .TWI_A_O(twi_a), .TWI_D_O(twi_d),
    .TWI_DONE_I(twi_done), .TWI_ERR_I(twi_err)
  );

  adau1761_cfg_seq #(
    .CLOCKFREQ(FREQ), .DEV_ADDR(8'h76), .MAX_RETRY(MAXR), .GAP_US(GAPU), .XFER_TIMEOUT_MS(TOMS),
    .ROM_OVR_EN(1'b1), .ROM_OVR_TBL(WRAP_TBL), .ROM_OVR_FILL(mk_dly(16'd0))
  ) dut_wrap (
    .CLK(clk), .SRST(srst), .START_I(w_start), .BUSY_O(w_busy), .DONE_O(w_done), .ERR_O(w_err),
    .ERR_IDX_O(w_err_idx), .TWI_STB_O(w_stb), .TWI_A_O(w_twi_a), .TWI_D_O(w_twi_d),
    .TWI_DONE_I(w_twi_done), .TWI_ERR_I(w_twi_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int nack_cnt [8];
  int nack_pos [8][5];
  int given [8];
  int abyte, cur_e, lat;
  bit silent;
  logic [7:0] log_q [$];
  logic [7:0] exp_q [$];
  logic [511:0] tbl_bits;

  int cyc = 0;
  int run_len = 0;
  logic prev_stb = 1'b0;
  bit w_stb_seen = 1'b0;
  int rise_q [$];
  int fall_q [$];
  int len_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lo2ent(input logic [7:0] lo);
    case (lo)
      8'h00:   return 0;
      8'h15:   return 1;
      8'h17:   return 2;
      8'h1C:   return 4;
      default: return 7;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int b);
    if (b == 0) return w[23:16];
    if (b == 1) return w[15:8];
    return w[7:0];
  endfunction

  // STB pulse monitor: rise/fall cycle stamps and high-time per attempt.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (stb && !prev_stb) rise_q.push_back(cyc);
    if (!stb && prev_stb) begin
      fall_q.push_back(cyc);
      len_q.push_back(run_len);
      run_len = 0;
    end
    if (stb) run_len = run_len + 1;
    prev_stb = stb;
    if (w_stb) w_stb_seen = 1'b1;
  end

  // I2C controller model: random byte latency, NACKs per entry at a chosen byte position.
  initial begin
    twi_done = 1'b0;
    twi_err  = 1'b0;
    forever begin
      @(negedge clk);
      twi_done = 1'b0;
      twi_err  = 1'b0;
      if (stb && !srst && !silent) begin
        if (lat != 0) begin
          lat = lat - 1;
        end else begin
          bit nk;
          if (abyte == 1) cur_e = lo2ent(twi_d);
          nk = (abyte != 0) && (given[cur_e] < nack_cnt[cur_e]) &&
               (abyte == nack_pos[cur_e][given[cur_e]]);
          log_q.push_back(twi_d);
          twi_done = 1'b1;
          twi_err  = nk;
          if (nk) begin
            given[cur_e] = given[cur_e] + 1;
            abyte = 0;
          end else begin
            abyte = (abyte == 2) ? 0 : abyte + 1;
          end
          lat = $urandom_range(0, 3);
        end
      end
    end
  end

  // Reference: walk the table, expand each write into its byte stream per attempt.
  task automatic ref_model(output int e_err, output int e_idx, output int e_att);
    logic [31:0] w;
    int e;
    bit fin;
    exp_q.delete();
    e_err = 0; e_idx = 0; e_att = 0; fin = 0;
    for (int i = 0; i < 256 && !fin; i++) begin
      if (i < 16) w = tbl_bits[i*32 +: 32];
      else w = ENTRY_END;
      case (w[31:30])
        2'b01: ;
        2'b00: begin
          e = lo2ent(w[15:8]);
          for (int a = 0; a <= int'(MAXR); a++) begin
            e_att++;
            if (silent || a < nack_cnt[e]) begin
              if (!silent)
                for (int b = 0; b <= nack_pos[e][a]; b++) exp_q.push_back(byte_of(w, b));
              if (a == int'(MAXR)) begin
                e_err = 1; e_idx = i; fin = 1;
              end
            end else begin
              for (int b = 0; b < 3; b++) exp_q.push_back(byte_of(w, b));
              break;
            end
          end
        end
        default: fin = 1;
      endcase
    end
    if (!fin) begin
      e_err = 1; e_idx = 255;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) given[i] = 0;
    abyte = 0;
    cur_e = 7;
    lat = $urandom_range(0, 3);
    log_q.delete();
    rise_q.delete();
    fall_q.delete();
    len_q.delete();
  endtask

  task automatic clear_nacks();
    for (int i = 0; i < 8; i++) begin
      nack_cnt[i] = 0;
      for (int j = 0; j < 5; j++) nack_pos[i][j] = $urandom_range(1, 2);
    end
  endtask

  task automatic run_seq(input string tag, input int budget, input bit extra_start);
    int e_err, e_idx, e_att, n;
    model_reset();
    ref_model(e_err, e_idx, e_att);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "/busy_next"}, busy, 1);
    check({tag, "/stb_not_yet"}, stb, 0);
    @(negedge clk);
    check({tag, "/stb_2cyc"}, stb, 1);
    if (extra_start) begin
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    for (int c = 0; c < budget; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check({tag, "/finished"}, busy, 0);
    @(negedge clk);
    check({tag, "/done"}, done, (e_err == 0) ? 1 : 0);
    check({tag, "/err"}, err, e_err);
    if (e_err != 0) check({tag, "/err_idx"}, err_idx, e_idx);
    check({tag, "/attempts"}, rise_q.size(), e_att);
    check({tag, "/nbytes"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s/byte%0d", tag, i), log_q[i], exp_q[i]);
    check({tag, "/twi_a"}, twi_a, 8'h76);
  endtask

  initial begin
    int g;
    srst = 1'b1; start = 1'b0; w_start = 1'b0; w_twi_done = 1'b0; w_twi_err = 1'b0;
    silent = 1'b0;
    tbl_bits = TEST_TBL;
    clear_nacks();
    model_reset();
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/err", err, 0);
    check("rst/err_idx", err_idx, 0);
    check("rst/stb", stb, 0);
    check("rst/twi_d", twi_d, 0);
    check("rst/twi_a", twi_a, 8'h76);

    run_seq("ack", 5000, 1'b0);
    check("ack/falls", fall_q.size() >= 3, 1);
    check("ack/rises", rise_q.size() >= 4, 1);
    if (fall_q.size() >= 3 && rise_q.size() >= 4) begin
      g = rise_q[3] - fall_q[2];
      check("ack/delay_gap_min", g >= 2 * MSC + GAPC, 1);
      check("ack/delay_gap_max", g <= 2 * MSC + GAPC + 4, 1);
    end

    clear_nacks();
    nack_cnt[1] = 2;
    run_seq("nack1x2", 5000, 1'b0);

    clear_nacks();
    nack_cnt[2] = 4;
    run_seq("nack2_all", 5000, 1'b0);
    check("nack2_all/both", done & err, 0);

    clear_nacks();
    silent = 1'b1;
    run_seq("wdog", 4 * (TOC + GAPC + 10), 1'b0);
    silent = 1'b0;
    check("wdog/nlen", len_q.size(), 4);
    foreach (len_q[i]) check($sformatf("wdog/len%0d", i), len_q[i], TOC);

    clear_nacks();
    model_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (log_q.size() >= 1) break;
      @(negedge clk);
    end
    check("srst/byte0_seen", log_q.size() >= 1, 1);
    srst = 1'b1;
    @(negedge clk);
    check("srst/stb", stb, 0);
    check("srst/busy", busy, 0);
    check("srst/done", done, 0);
    srst = 1'b0;
    run_seq("restart", 5000, 1'b1);

    for (int r = 0; r < 3; r++) begin
      clear_nacks();
      foreach (nack_cnt[e])
        nack_cnt[e] = ($urandom_range(0, 5) == 5) ? 4 : $urandom_range(0, 2);
      run_seq($sformatf("rand%0d", r), 8000, 1'b0);
    end

    @(negedge clk); w_start = 1'b1;
    @(negedge clk); w_start = 1'b0;
    check("wrap/busy_next", w_busy, 1);
    for (int c = 0; c < 2000; c++) begin
      if (!w_busy) break;
      @(negedge clk);
    end
    check("wrap/finished", w_busy, 0);
    check("wrap/err", w_err, 1);
    check("wrap/err_idx", w_err_idx, 8'hFF);
    check("wrap/done", w_done, 0);
    check("wrap/no_stb", w_stb_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
